// File: rtl/mem_access_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_access_controller : program-load / instruction-fetch sequencer. Rev 1.0
// ---------------------------------------------------------------------------
module mem_access_controller #(
  parameter int               DW        = 32,
  parameter int               ADDR_STEP = 4,
  parameter logic [DW-1:0]    BASE_ADDR = '0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic [DW-1:0]    load_data_i,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic             fetch_en_i,
  input  logic             branch_i,
  input  logic [DW-1:0]    branch_target_i,
  output logic [DW-1:0]    instr_o,
  output logic             instr_valid_o,
  input  logic             instr_ready_i,
  output logic             busy_o,
  output logic             Write_Enable_o,
  output logic [DW-1:0]    Write_Data_o,
  output logic [DW-1:0]    Address_o,
  input  logic [DW-1:0]    Instruction_i
);

  localparam logic [1:0]       c_IDLE  = 2'd0;
  localparam logic [1:0]       c_LOAD  = 2'd1;
  localparam logic [1:0]       c_FETCH = 2'd2;
  localparam logic [DW-1:0]    c_step  = DW'(ADDR_STEP);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [1:0]       r_state;
  logic [DW-1:0]    r_pc;
  logic [DW-1:0]    r_load_addr;
  logic [CNT_W-1:0] r_remaining;
  logic [DW-1:0]    r_instr;
  logic             r_instr_valid;

  logic w_in_load;
  logic w_accept;

  assign w_in_load      = (r_state == c_LOAD);
  assign w_accept       = w_in_load & load_valid_i;
  assign load_ready_o   = w_in_load;
  assign Write_Enable_o = w_accept;
  assign Write_Data_o   = load_data_i;
  assign Address_o      = w_in_load ? r_load_addr : r_pc;
  assign busy_o         = (r_state != c_IDLE);
  assign instr_o        = r_instr;
  assign instr_valid_o  = r_instr_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_IDLE;
      r_pc          <= BASE_ADDR;
      r_load_addr   <= BASE_ADDR;
      r_remaining   <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (branch_i)
            r_pc <= branch_target_i;
          if (load_start_i && (load_count_i != '0)) begin
            r_state     <= c_LOAD;
            r_remaining <= load_count_i;
            r_load_addr <= BASE_ADDR;
          end else if (fetch_en_i) begin
            r_state <= c_FETCH;
          end
        end
        c_LOAD: begin
          if (w_accept) begin
            r_load_addr <= r_load_addr + c_step;
            if (r_remaining != '0)
              r_remaining <= r_remaining - c_one;
            // Last word of the burst: return to IDLE ready to fetch from the start.
            if (r_remaining == c_one) begin
              r_state <= c_IDLE;
              r_pc    <= BASE_ADDR;
            end
          end
        end
        c_FETCH: begin
          if (!fetch_en_i) begin
            r_state       <= c_IDLE;
            r_instr_valid <= 1'b0;
          end else if (branch_i) begin
            r_pc          <= branch_target_i;
            r_instr_valid <= 1'b0;
          end else if (!r_instr_valid || instr_ready_i) begin
            r_instr       <= Instruction_i;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + c_step;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
